// File: rtl/bcd_pkg.sv
// Shared constants and types for the BCD to Excess-3 converter.
package bcd_pkg;

    typedef logic [3:0] nibble_t;

    localparam nibble_t XS3_OFFSET  = 4'd3;
    localparam nibble_t BCD_MAX     = 4'd9;
    localparam nibble_t XS3_INVALID = 4'b0000;

endpackage : bcd_pkg

// File: rtl/bcd_digit_to_xs3.sv
// Combinational single-digit BCD to Excess-3 conversion with illegal-digit flag.
module bcd_digit_to_xs3
    import bcd_pkg::*;
(
    input  logic [3:0] i_bcd,
    output logic [3:0] o_xs3,
    output logic       o_err
);

    always_comb begin
        o_xs3 = XS3_INVALID;
        o_err = 1'b1;
        // Digits above 9 have no XS3 code; emit the unused 0000 pattern instead.
        if (i_bcd <= BCD_MAX) begin
            o_xs3 = i_bcd + XS3_OFFSET;
            o_err = 1'b0;
        end
    end

endmodule : bcd_digit_to_xs3

// File: rtl/bcd_to_xs3.sv
// Registered multi-digit BCD to Excess-3 converter, one cycle latency.
module bcd_to_xs3
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [4*DIGITS-1:0]   bcd,
    output logic                  out_valid,
    output logic [4*DIGITS-1:0]   xs3,
    output logic [DIGITS-1:0]     err
);

    logic [4*DIGITS-1:0] w_xs3;
    logic [DIGITS-1:0]   w_err;

    logic                r_valid;
    logic [4*DIGITS-1:0] r_xs3;
    logic [DIGITS-1:0]   r_err;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_to_xs3 u_digit (
            .i_bcd (bcd[4*k +: 4]),
            .o_xs3 (w_xs3[4*k +: 4]),
            .o_err (w_err[k])
        );
    end

    // Data registers load only on valid words so an undriven bus stays out of the outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_xs3   <= '0;
            r_err   <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_xs3 <= w_xs3;
                r_err <= w_err;
            end
        end
    end

    assign out_valid = r_valid;
    assign xs3       = r_xs3;
    assign err       = r_err;

endmodule : bcd_to_xs3

// File: tb/tb_bcd_to_xs3.sv
// Bench for bcd_to_xs3 with one-digit and four-digit instances against an arithmetic model.
module tb_bcd_to_xs3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] bcd4 = '0;
    logic [3:0]  bcd1 = '0;

    logic        ov1, ov4;
    logic [3:0]  xs1;
    logic [0:0]  er1;
    logic [15:0] xs4;
    logic [3:0]  er4;

    int errors = 0;
    int checks = 0;

    logic        exp_v;
    logic [3:0]  exp_x1;
    logic        exp_e1;
    logic [15:0] exp_x4;
    logic [3:0]  exp_e4;

    always #5 clk = ~clk;

    bcd_to_xs3 #(.DIGITS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .bcd(bcd1),
        .out_valid(ov1), .xs3(xs1), .err(er1)
    );

    bcd_to_xs3 #(.DIGITS(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .bcd(bcd4),
        .out_valid(ov4), .xs3(xs4), .err(er4)
    );

    // Excess-3 is digit value plus three; digits above nine are illegal and give zero.
    function automatic void model(input logic [15:0] b, output logic [15:0] x, output logic [3:0] e);
        int d;
        x = '0;
        e = '0;
        for (int k = 0; k < 4; k++) begin
            d = (int'(b) >> (4 * k)) % 16;
            if (d < 10) x = x | 16'((d + 3) << (4 * k));
            else        e[k] = 1'b1;
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".ov1"}, 32'(ov1), 32'(exp_v));
        chk({tag, ".xs1"}, 32'(xs1), 32'(exp_x1));
        chk({tag, ".er1"}, 32'(er1), 32'(exp_e1));
        chk({tag, ".ov4"}, 32'(ov4), 32'(exp_v));
        chk({tag, ".xs4"}, 32'(xs4), 32'(exp_x4));
        chk({tag, ".er4"}, 32'(er4), 32'(exp_e4));
    endtask

    // Drive one word, let one edge pass, then compare both instances.
    task automatic step(input string tag, input logic v, input logic [15:0] b);
        logic [15:0] x;
        logic [3:0]  e;
        in_valid = v;
        bcd4 = b;
        bcd1 = b[3:0];
        @(posedge clk);
        #1;
        exp_v = v;
        if (v) begin
            model(b, exp_x4, exp_e4);
            model({12'h000, b[3:0]}, x, e);
            exp_x1 = x[3:0];
            exp_e1 = e[0];
        end
        chk_all(tag);
    endtask

    initial begin
        exp_v = 1'b0; exp_x1 = '0; exp_e1 = 1'b0; exp_x4 = '0; exp_e4 = '0;

        // Held in reset with live stimulus: outputs must stay cleared.
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'(i % 2 == 0);
            bcd4 = 16'($urandom);
            bcd1 = bcd4[3:0];
            @(posedge clk);
            #1;
            chk_all("reset");
        end
        in_valid = 1'b0;
        rst_n = 1'b1;

        for (int d = 0; d < 16; d++) begin
            step("sweep", 1'b1, 16'(d) | 16'h9870);
            chk("sweep.const", 32'(xs1), (d < 10) ? 32'(d + 3) : 32'h0);
        end

        step("dig4", 1'b1, 16'h1A93);
        chk("dig4.xs.const", 32'(xs4), 32'h40C6);
        chk("dig4.err.const", 32'(er4), 32'h4);

        step("pat.a", 1'b1, 16'h0002);
        chk("pat.a.const", 32'(xs1), 32'h5);
        step("pat.b", 1'b0, 16'bx);
        chk("pat.b.hold", 32'(xs1), 32'h5);
        step("pat.c", 1'b1, 16'h0008);
        chk("pat.c.const", 32'(xs1), 32'hB);

        for (int i = 0; i < 200; i++) begin
            logic v;
            v = 1'($urandom_range(0, 3) != 0);
            if (v) step("rand", 1'b1, 16'($urandom));
            else   step("rand.idle", 1'b0, ($urandom_range(0, 1) != 0) ? 16'bx : 16'($urandom));
        end

        // Asynchronous reset between edges with a valid word pending.
        step("pre_rst", 1'b1, 16'h0555);
        in_valid = 1'b1;
        bcd4 = 16'h1234;
        bcd1 = 4'h4;
        #2;
        rst_n = 1'b0;
        #1;
        exp_v = 1'b0; exp_x1 = '0; exp_e1 = 1'b0; exp_x4 = '0; exp_e4 = '0;
        chk_all("async_rst");
        @(posedge clk);
        #1;
        chk_all("rst_hold");
        in_valid = 1'b0;
        rst_n = 1'b1;
        step("post_rst", 1'b0, 16'h3333);
        step("post_rst2", 1'b0, 16'bx);
        step("restart", 1'b1, 16'h9999);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_bcd_to_xs3
